// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: shares one SD sector-read engine between the cache-fill
// port (0) and the host loader port (1), forwarding the returned sector
// bytes tagged with the owning port and reporting per-transfer status.
module sd_sector_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned MAX_STREAK     = 4,
  parameter int unsigned LBA_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sd_present,
  input  logic             req0_valid,
  input  logic [LBA_W-1:0] req0_lba,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [LBA_W-1:0] req1_lba,
  output logic             req1_ready,
  output logic             eng_cmd_valid,
  output logic [LBA_W-1:0] eng_cmd_lba,
  input  logic             eng_cmd_ready,
  input  logic             eng_data_valid,
  input  logic [7:0]       eng_data,
  input  logic             eng_done,
  input  logic             eng_err,
  output logic             eng_abort,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_port,
  output logic             done_valid,
  output logic             done_err,
  output logic             busy
);

  localparam int unsigned TMR_W        = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STRK_W       = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_ABORT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [STRK_W-1:0]  streak_q, streak_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               overrun_q, overrun_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic               port_q, port_d;
  logic               hold_q, hold_d;
  logic               req0_ready_q, req0_ready_d;
  logic               req1_ready_q, req1_ready_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               abort_q, abort_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               done_valid_q, done_valid_d;
  logic               done_err_q, done_err_d;
  logic               busy_q, busy_d;

  logic               timeout_c;
  logic               abort_req_c;
  logic               grant_ok_c;
  logic               pick1_c;
  logic [TMR_W-1:0]   timer_inc_c;

  // Arbitration, timeout and stream-accounting helpers.
  always_comb begin
    timeout_c   = (timer_q >= TMR_W'(TIMEOUT_CYCLES));
    abort_req_c = timeout_c | ~sd_present;
    timer_inc_c = timeout_c ? timer_q : timer_q + TMR_W'(1);
    // Two quiet cycles after every done pulse before the next grant is sampled.
    grant_ok_c  = sd_present & ~done_valid_q & ~hold_q;
    pick1_c     = req1_valid & (~req0_valid | (streak_q == STRK_W'(MAX_STREAK)));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    overrun_d    = overrun_q;
    lba_d        = lba_q;
    port_d       = port_q;
    hold_d       = done_valid_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_last_d   = 1'b0;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_ok_c && (req0_valid || req1_valid)) begin
          state_d    = ST_ISSUE;
          timer_d    = TMR_W'(1);
          byte_cnt_d = '0;
          overrun_d  = 1'b0;
          if (pick1_c) begin
            port_d       = 1'b1;
            lba_d        = req1_lba;
            req1_ready_d = 1'b1;
            streak_d     = '0;
          end else begin
            port_d       = 1'b0;
            lba_d        = req0_lba;
            req0_ready_d = 1'b1;
            streak_d     = req1_valid ? streak_q + STRK_W'(1) : '0;
          end
        end
      end

      ST_ISSUE: begin
        timer_d = timer_inc_c;
        if (eng_done) begin
          // Engine finished before accepting a command: no data, so a failure.
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = '0;
        end else if (abort_req_c) begin
          state_d = ST_ABORT;
        end else if (eng_cmd_ready) begin
          state_d    = ST_STREAM;
          byte_cnt_d = '0;
        end
      end

      ST_STREAM: begin
        timer_d = timer_inc_c;
        if (eng_data_valid) begin
          if (byte_cnt_q == CNT_W'(SECTOR_BYTES)) begin
            overrun_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = eng_data;
            out_last_d  = (byte_cnt_q == CNT_W'(SECTOR_BYTES - 1));
            byte_cnt_d  = byte_cnt_q + CNT_W'(1);
          end
        end
        // A byte arriving with done is already counted in byte_cnt_d.
        if (eng_done) begin
          done_valid_d = 1'b1;
          done_err_d   = eng_err | overrun_d | (byte_cnt_d != CNT_W'(SECTOR_BYTES));
          state_d      = ST_IDLE;
          timer_d      = '0;
        end else if (abort_req_c) begin
          state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        if (eng_done) begin
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_valid_d = (state_d == ST_ISSUE);
    abort_d     = (state_d == ST_ABORT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak_q     <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      overrun_q    <= 1'b0;
      lba_q        <= '0;
      port_q       <= 1'b0;
      hold_q       <= 1'b0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      abort_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      streak_q     <= streak_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      overrun_q    <= overrun_d;
      lba_q        <= lba_d;
      port_q       <= port_d;
      hold_q       <= hold_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      cmd_valid_q  <= cmd_valid_d;
      abort_q      <= abort_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready    = req0_ready_q;
  assign req1_ready    = req1_ready_q;
  assign eng_cmd_valid = cmd_valid_q;
  assign eng_cmd_lba   = lba_q;
  assign eng_abort     = abort_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_port      = port_q;
  assign done_valid    = done_valid_q;
  assign done_err      = done_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Testbench for sd_sector_arbiter: directed and randomized transfers checked
// against a transfer-level model of arbitration, forwarding and status.
module tb_sd_sector_arbiter;

  localparam int unsigned TMO  = 1000;
  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_present;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_lba, req1_lba;
  logic        req0_ready, req1_ready;
  logic        eng_cmd_valid;
  logic [31:0] eng_cmd_lba;
  logic        eng_cmd_ready;
  logic        eng_data_valid;
  logic [7:0]  eng_data;
  logic        eng_done, eng_err, eng_abort;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last, out_port;
  logic        done_valid, done_err, busy;

  int unsigned cyc = 0;
  int unsigned t_done = 0;
  int unsigned t_grant = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          model_streak = 0;
  bit          last_port = 1'b0;

  sd_sector_arbiter #(.TIMEOUT_CYCLES(TMO), .MAX_STREAK(MAXS), .LBA_W(32)) dut (
    .clk(clk), .rst(rst), .sd_present(sd_present),
    .req0_valid(req0_valid), .req0_lba(req0_lba), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_lba(req1_lba), .req1_ready(req1_ready),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_lba(eng_cmd_lba), .eng_cmd_ready(eng_cmd_ready),
    .eng_data_valid(eng_data_valid), .eng_data(eng_data), .eng_done(eng_done),
    .eng_err(eng_err), .eng_abort(eng_abort),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_port(out_port),
    .done_valid(done_valid), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: port 1 wins if it asks and port 0 is idle or has used its streak.
  function automatic bit predict(input bit r0, input bit r1);
    return r1 && (!r0 || model_streak == MAXS);
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_r0"},    64'(req0_ready), 64'(0));
    chk({tag, "_r1"},    64'(req1_ready), 64'(0));
    chk({tag, "_cmd"},   64'(eng_cmd_valid), 64'(0));
    chk({tag, "_lba"},   64'(eng_cmd_lba), 64'(0));
    chk({tag, "_abort"}, 64'(eng_abort), 64'(0));
    chk({tag, "_ov"},    64'(out_valid), 64'(0));
    chk({tag, "_od"},    64'(out_data), 64'(0));
    chk({tag, "_ol"},    64'(out_last), 64'(0));
    chk({tag, "_op"},    64'(out_port), 64'(0));
    chk({tag, "_dv"},    64'(done_valid), 64'(0));
    chk({tag, "_de"},    64'(done_err), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
  endtask

  task automatic wait_grant(input bit r0, input bit r1, input logic [31:0] l0,
                            input logic [31:0] l1, input bit keep, input bit spacing);
    bit exp_port;
    int waited;
    exp_port   = predict(r0, r1);
    req0_valid = r0;
    req1_valid = r1;
    req0_lba   = l0;
    req1_lba   = l1;
    waited     = 0;
    do begin
      step();
      waited++;
    end while (!(req0_ready === 1'b1 || req1_ready === 1'b1) && waited < 20);
    chk("grant_seen", 64'(req0_ready | req1_ready), 64'(1));
    t_grant = cyc;
    if (spacing) chk("done_to_ready", 64'(cyc - t_done), 64'(3));
    chk("grant_port", 64'(req1_ready), 64'(exp_port));
    chk("grant_one",  64'(req0_ready & req1_ready), 64'(0));
    chk("grant_cmd",  64'(eng_cmd_valid), 64'(1));
    chk("grant_busy", 64'(busy), 64'(1));
    chk("grant_lba",  64'(eng_cmd_lba), 64'(exp_port ? l1 : l0));
    if (exp_port) model_streak = 0;
    else          model_streak = r1 ? model_streak + 1 : 0;
    last_port = exp_port;
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic accept_cmd(input int dly);
    for (int i = 0; i < dly; i++) begin
      step();
      chk("cmd_hold", 64'(eng_cmd_valid), 64'(1));
      chk("ready_pulse", 64'(req0_ready | req1_ready), 64'(0));
    end
    eng_cmd_ready = 1'b1;
    step();
    eng_cmd_ready = 1'b0;
    chk("cmd_drop", 64'(eng_cmd_valid), 64'(0));
    chk("ready_pulse", 64'(req0_ready | req1_ready), 64'(0));
  endtask

  task automatic send_bytes(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      eng_data_valid = 1'b1;
      eng_data = b;
      step();
      chk("fwd_valid", 64'(out_valid), 64'(1));
      chk("fwd_data",  64'(out_data), 64'(b));
      chk("fwd_port",  64'(out_port), 64'(last_port));
    end
    eng_data_valid = 1'b0;
  endtask

  // One sector stream: n bytes, done either with the last byte or one cycle later.
  task automatic stream(input int n, input bit pat, input bit err, input bit with_last);
    logic [7:0] b;
    bit exp_err;
    exp_err = err || (n != 512);
    for (int i = 0; i < n; i++) begin
      b = pat ? 8'(i) : 8'($urandom);
      eng_data_valid = 1'b1;
      eng_data = b;
      eng_done = with_last && (i == n - 1);
      eng_err  = eng_done & err;
      step();
      chk("s_valid", 64'(out_valid), 64'(i < 512));
      if (i < 512) begin
        chk("s_data", 64'(out_data), 64'(b));
        chk("s_last", 64'(out_last), 64'(i == 511));
        chk("s_port", 64'(out_port), 64'(last_port));
      end
      if (eng_done) begin
        chk("s_done", 64'(done_valid), 64'(1));
        chk("s_err",  64'(done_err), 64'(exp_err));
        chk("s_busy", 64'(busy), 64'(0));
        t_done = cyc;
      end else begin
        chk("s_nodone", 64'(done_valid), 64'(0));
      end
    end
    eng_data_valid = 1'b0;
    eng_done = 1'b0;
    eng_err  = 1'b0;
    if (!with_last) begin
      eng_done = 1'b1;
      eng_err  = err;
      step();
      eng_done = 1'b0;
      eng_err  = 1'b0;
      chk("d_ov",   64'(out_valid), 64'(0));
      chk("d_done", 64'(done_valid), 64'(1));
      chk("d_err",  64'(done_err), 64'(exp_err));
      chk("d_port", 64'(out_port), 64'(last_port));
      chk("d_busy", 64'(busy), 64'(0));
      t_done = cyc;
    end
    step();
    chk("done_pulse", 64'(done_valid), 64'(0));
  endtask

  initial begin
    int lens [6];
    int w;
    rst = 1'b0; sd_present = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_lba = '0; req1_lba = '0;
    eng_cmd_ready = 1'b0; eng_data_valid = 1'b0; eng_data = '0;
    eng_done = 1'b0; eng_err = 1'b0;
    lens = '{510, 511, 512, 512, 513, 514};

    // Reset state.
    step(); step();
    all_zero("reset");
    rst = 1'b1;
    step();

    // Single port-0 read with counting pattern.
    wait_grant(1'b1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    accept_cmd(1);
    stream(512, 1'b1, 1'b0, 1'b0);

    // Both ports continuously requesting: streak fairness and done-to-grant spacing.
    for (int k = 0; k < 10; k++) begin
      wait_grant(1'b1, 1'b1, 32'h100 + 32'(k), 32'h200 + 32'(k), 1'b1, k > 0);
      chk("streak_seq", 64'(last_port), 64'(k == 4 || k == 9));
      accept_cmd(0);
      stream((k % 3 == 0) ? 16 : 512, 1'b0, 1'b0, 1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Length and status boundaries.
    wait_grant(1'b1, 1'b0, 32'hA, 32'h0, 1'b0, 1'b0); accept_cmd(0); stream(511, 1'b0, 1'b0, 1'b0);
    wait_grant(1'b0, 1'b1, 32'h0, 32'hB, 1'b0, 1'b0); accept_cmd(2); stream(513, 1'b0, 1'b0, 1'b1);
    wait_grant(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0); accept_cmd(0); stream(512, 1'b0, 1'b1, 1'b1);
    wait_grant(1'b1, 1'b0, 32'hD, 32'h0, 1'b0, 1'b0); accept_cmd(3); stream(512, 1'b0, 1'b0, 1'b1);

    // Timeout: engine goes silent mid-sector.
    wait_grant(1'b1, 1'b0, 32'hE, 32'h0, 1'b0, 1'b0);
    accept_cmd(2);
    send_bytes(10);
    w = 0;
    while (eng_abort !== 1'b1 && w < 1100) begin step(); w++; end
    chk("abort_seen",    64'(eng_abort), 64'(1));
    chk("abort_latency", 64'(cyc - t_grant), 64'(TMO));
    chk("abort_cmd",     64'(eng_cmd_valid), 64'(0));
    chk("abort_busy",    64'(busy), 64'(1));
    eng_data_valid = 1'b1; eng_data = 8'h5A;
    step();
    eng_data_valid = 1'b0;
    chk("abort_drop", 64'(out_valid), 64'(0));
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("tmo_done", 64'(done_valid), 64'(1));
    chk("tmo_err",  64'(done_err), 64'(1));
    chk("tmo_busy", 64'(busy), 64'(0));
    chk("tmo_abort_clr", 64'(eng_abort), 64'(0));
    step();

    // Card removal mid-stream; no grant while the card is absent.
    wait_grant(1'b1, 1'b0, 32'hF00D, 32'h0, 1'b0, 1'b0);
    accept_cmd(0);
    send_bytes(100);
    sd_present = 1'b0;
    req0_valid = 1'b1; req0_lba = 32'hBEEF;
    step();
    chk("rm_abort", 64'(eng_abort), 64'(1));
    chk("rm_ov",    64'(out_valid), 64'(0));
    for (int i = 0; i < 5; i++) begin
      eng_data_valid = 1'b1; eng_data = 8'(i);
      step();
      chk("rm_late", 64'(out_valid), 64'(0));
    end
    eng_data_valid = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("rm_done", 64'(done_valid), 64'(1));
    chk("rm_err",  64'(done_err), 64'(1));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rm_noready", 64'(req0_ready), 64'(0));
    end
    sd_present = 1'b1;
    wait_grant(1'b1, 1'b0, 32'hBEEF, 32'h0, 1'b0, 1'b0);
    accept_cmd(1);
    stream(512, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream on port 1.
    wait_grant(1'b0, 1'b1, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0);
    accept_cmd(0);
    send_bytes(50);
    rst = 1'b0;
    step();
    all_zero("midrst");
    rst = 1'b1;
    model_streak = 0;
    step();
    chk("midrst_nodone", 64'(done_valid), 64'(0));
    chk("midrst_busy",   64'(busy), 64'(0));
    wait_grant(1'b1, 1'b0, 32'h0000_0777, 32'h0, 1'b0, 1'b0);
    accept_cmd(0);
    stream(512, 1'b0, 1'b0, 1'b0);

    // Randomized transfers.
    for (int k = 0; k < 6; k++) begin
      int unsigned r;
      bit r0, r1, e, wl;
      int n, d;
      r  = $urandom_range(1, 3);
      r0 = r[0];
      r1 = r[1];
      e  = ($urandom_range(0, 3) == 0);
      wl = 1'($urandom_range(0, 1));
      n  = lens[$urandom_range(0, 5)];
      d  = int'($urandom_range(0, 3));
      wait_grant(r0, r1, $urandom, $urandom, 1'b0, 1'b0);
      accept_cmd(d);
      stream(n, 1'b0, e, wl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
# sd_sector_arbiter

Shares the single SD-card SPI sector-read engine between two requesters in GameBrian: port 0, the GBA ROM-miss cache fill path, and port 1, the serial host loader/debug path. The block arbitrates, issues one 512-byte sector read at a time to the engine, and tags the returned byte stream with the owning port. It also aborts on timeout or card removal and reports per-transfer completion and error status. It sits between the GBA bus logic and UART command logic on one side and the SPI sector engine on the other, in the main `clk` domain.

## Interface
- TIMEOUT_CYCLES, 2_000_000: max cycles in ISSUE+STREAM before abort (10 ms at 200 MHz)
- MAX_STREAK, 4: consecutive port-0 grants allowed while port 1 waits
- LBA_W, 32: sector address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- sd_present  in  1  debounced card detect, 1 = card inserted
- req0_valid / req1_valid  in  1  read request, held until ready
- req0_lba / req1_lba  in  LBA_W  sector address, stable while valid
- req0_ready / req1_ready  out  1  one-cycle accept pulse
- eng_cmd_valid  out  1  command to engine, held until eng_cmd_ready
- eng_cmd_lba  out  LBA_W  latched LBA of granted request
- eng_cmd_ready  in  1  engine accepts command
- eng_data_valid  in  1  one sector byte
- eng_data  in  8  byte value
- eng_done  in  1  engine finished or aborted (pulse)
- eng_err  in  1  engine error, qualified by eng_done
- eng_abort  out  1  abort request, held until eng_done
- out_valid  out  1  forwarded byte
- out_data  out  8  byte value
- out_last  out  1  marks byte 511
- out_port  out  1  owner of out_* and done_*
- done_valid  out  1  transfer-complete pulse
- done_err  out  1  1 = transfer failed, qualified by done_valid
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, STREAM, ABORT.
- IDLE:
  - If sd_present=0, no grant is made and both ready outputs stay low.
  - Otherwise the arbiter picks a winner. Port 0 wins unless req1_valid=1 and either req0_valid=0 or streak==MAX_STREAK.
  - On grant: latch LBA and port, pulse reqX_ready, go to ISSUE.
- Streak counter:
  - Increments on a port-0 grant while req1_valid=1.
  - Clears on a port-1 grant, and on a port-0 grant while req1_valid=0.
- ISSUE: eng_cmd_valid=1. On eng_cmd_ready, go to STREAM and clear byte_cnt. The timer runs from the grant.
- STREAM:
  - Each eng_data_valid is forwarded and byte_cnt (10 bit) increments.
  - Bytes arriving when byte_cnt==512 are dropped and set the overrun flag.
  - On eng_done, emit done with done_err = eng_err | overrun | (byte_cnt != 512), then go to IDLE.
- Abort: timer reaching TIMEOUT_CYCLES, or sd_present falling, in ISSUE or STREAM sends the FSM to ABORT.
  - In ABORT: eng_cmd_valid=0 and eng_abort=1; late bytes are dropped.
  - On eng_done, emit done with done_err=1 and go to IDLE.
  - The timeout does not apply in ABORT.
- Simultaneous events:
  - eng_done together with timeout or card removal: done wins, with normal status.
  - eng_data_valid together with eng_done: the byte is counted before the status check.
- Reset mid-transfer: all state clears with no done pulse. The engine is reset by the same `rst`.

## Timing
- Reset values:
  - All outputs are 0: ready, eng_cmd_valid, eng_cmd_lba, eng_abort, out_*, done_*, busy.
  - FSM is IDLE, streak=0, byte_cnt=0, timer=0, overrun=0.
- Grant: request sampled at edge N. At cycle N+1, reqX_ready is high for exactly one cycle, and eng_cmd_valid and busy go high.
- The requester must deassert valid or present a new request after ready. A request still held is regranted no earlier than one IDLE cycle after done.
- Forwarding latency is 1 cycle: eng_data_valid at cycle K gives registered out_valid/out_data/out_port at K+1. out_last is high on the 512th forwarded byte.
- done_valid is a one-cycle pulse, registered 1 cycle after eng_done. busy falls in the same cycle.
- Minimum spacing is 3 cycles from one done_valid to the next grant's ready pulse (IDLE, arbitrate).
- Timer width is ceil(log2(TIMEOUT_CYCLES+1)) bits, saturating.

## Test plan
- Single port-0 read, LBA 0x00001234, engine returns 512 bytes 0x00..0xFF twice:
  - eng_cmd_lba=0x1234.
  - 512 out_valid with out_port=0, out_last on byte 511.
  - done_valid with done_err=0.
- Both ports request continuously with MAX_STREAK=4: grant order 0,0,0,0,1,0,0,0,0,1; streak clears after each port-1 grant.
- Engine sends 511 bytes then eng_done: done_err=1. Engine sends 513 bytes: byte 513 not forwarded and done_err=1.
- Engine never asserts eng_done, TIMEOUT_CYCLES=1000:
  - eng_abort rises 1000 cycles after grant.
  - After eng_done, done_valid with done_err=1, busy=0.
- sd_present drops mid-STREAM: ABORT entered next cycle and no further out_valid. While sd_present=0, req0_valid=1 yields no ready.
- rst low for one cycle mid-STREAM: next cycle all outputs 0, FSM IDLE, no done pulse. A new request is granted normally.
